// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - program memory port arbiter between CPU fetch and host loader
// CPU fetches win reads; an aging counter forces a host read through after MAX_HOST_WAIT denials.
module pmem_arbiter #(
  parameter int DATA_W        = 8,
  parameter int DEPTH         = 16,
  parameter int INIT_CYCLES   = DEPTH,
  parameter int MAX_HOST_WAIT = 4,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic [AW-1:0]     cpu_addr_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [AW-1:0]     host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              mem_wen_o,
  output logic [AW-1:0]     mem_waddr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_ren_o,
  output logic [AW-1:0]     mem_raddr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              ready_o
);

  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int WW = $clog2(MAX_HOST_WAIT + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_HOST_WAIT);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state;
  logic [IW-1:0]   init_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            rd_valid;
  logic            rd_owner;   // 1 = host owns the read in flight

  logic run;
  logic host_rd;
  logic host_wr;
  logic host_rd_win;

  assign run         = (state == RUN);
  assign host_rd     = host_req_i & ~host_we_i;
  assign host_wr     = host_req_i & host_we_i;
  assign host_rd_win = run & host_rd & (~cpu_req_i | (wait_cnt == WAIT_MAX));

  assign cpu_gnt_o   = run & cpu_req_i & ~host_rd_win;
  assign host_gnt_o  = host_rd_win | (run & host_wr);

  // Writes use the dedicated write port and never contend with fetches.
  assign mem_wen_o   = run & host_wr;
  assign mem_waddr_o = host_addr_i;
  assign mem_wdata_o = host_wdata_i;
  assign mem_ren_o   = cpu_gnt_o | host_rd_win;
  assign mem_raddr_o = host_rd_win ? host_addr_i : cpu_addr_i;

  assign cpu_rvalid_o  = rd_valid & ~rd_owner;
  assign host_rvalid_o = rd_valid & rd_owner;
  assign cpu_rdata_o   = mem_rdata_i;
  assign host_rdata_o  = mem_rdata_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= INIT;
      init_cnt <= '0;
      wait_cnt <= '0;
      ready_o  <= 1'b0;
      rd_valid <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_valid <= mem_ren_o;
      rd_owner <= host_rd_win;
      case (state)
        INIT: begin
          init_cnt <= init_cnt + IW'(1);
          if (init_cnt == INIT_LAST) begin
            state   <= RUN;
            ready_o <= 1'b1;
          end
        end
        RUN: begin
          if (host_rd && !host_rd_win) begin
            if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WW'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - scoreboard bench for pmem_arbiter with a write-first memory model
module tb_pmem_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_wen, mem_ren;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          ready;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] cpu_q[$];
  logic [DW-1:0] host_q[$];
  logic [DW-1:0] mem [16];

  always #5 clk = ~clk;

  pmem_arbiter #(.DATA_W(DW), .DEPTH(16), .INIT_CYCLES(16), .MAX_HOST_WAIT(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr), .cpu_gnt_o(cpu_gnt),
    .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_gnt_o(host_gnt),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
    .mem_wen_o(mem_wen), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata),
    .mem_ren_o(mem_ren), .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata),
    .ready_o(ready)
  );

  // Program memory model: reloads its image during reset, 1-cycle read, write-first.
  always @(posedge clk) begin
    if (!rst_i) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
      mem[0] <= 8'h45;
      mem[3] <= 8'h43;
      mem[5] <= 8'hFB;
      mem_rdata <= '0;
    end else begin
      if (mem_ren) mem_rdata <= (mem_wen && mem_waddr == mem_raddr) ? mem_wdata : mem[mem_raddr];
      if (mem_wen) mem[mem_waddr] <= mem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every rvalid pops the expected data pushed at grant time.
  always @(negedge clk) begin
    if (rst_i && cpu_rvalid) begin
      if (cpu_q.size() == 0) check_eq("cpu_spurious_rvalid", 1, 0);
      else check_eq("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
    end
    if (rst_i && host_rvalid) begin
      if (host_q.size() == 0) check_eq("host_spurious_rvalid", 1, 0);
      else check_eq("host_rdata", 32'(host_rdata), 32'(host_q.pop_front()));
    end
  end

  task automatic hold_off(input string tag);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); #1;
      check_eq(tag, {27'd0, cpu_gnt, host_gnt, mem_ren, mem_wen, ready}, 0);
    end
  endtask

  task automatic step(input logic c_req, input logic [AW-1:0] c_addr,
                      input logic h_req, input logic h_we, input logic [AW-1:0] h_addr,
                      input logic [DW-1:0] h_wdata);
    @(negedge clk);
    cpu_req = c_req; cpu_addr = c_addr;
    host_req = h_req; host_we = h_we; host_addr = h_addr; host_wdata = h_wdata;
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    cpu_req = 1'b1; cpu_addr = 4'd0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'd7; host_wdata = 8'h77;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {29'd0, ready, cpu_rvalid, host_rvalid}, 0);
    check_eq("reset_wait_cnt", 32'(dut.wait_cnt), 0);

    // Release reset mid-low-phase; 16 edges of hold-off follow.
    @(negedge clk); rst_i = 1'b1;
    @(posedge clk);
    for (int k = 2; k <= 16; k++) begin
      @(negedge clk); #1;
      check_eq("init_holdoff", {27'd0, cpu_gnt, host_gnt, mem_ren, mem_wen, ready}, 0);
      @(posedge clk);
    end
    #1;
    check_eq("ready_after_edge16", 32'(ready), 1);
    @(negedge clk); #1;
    check_eq("first_grants", {27'd0, cpu_gnt, host_gnt, mem_ren, mem_wen, ready}, 5'b11111);
    cpu_q.push_back(8'h45);

    // Fetch back what the host wrote during the first ready cycle.
    step(1, 4'd7, 0, 0, 4'd0, 8'h00);
    check_eq("fetch_written", {31'd0, cpu_gnt}, 1);
    cpu_q.push_back(8'h77);

    // Starvation guard: host read of address 3 under continuous fetch of address 1.
    for (int c = 1; c <= 5; c++) begin
      step(1, 4'd1, 1, 0, 4'd3, 8'h00);
      if (c <= 4) begin
        check_eq("starve_deny", {30'd0, cpu_gnt, host_gnt}, 2'b10);
        cpu_q.push_back(8'h11);
      end else begin
        check_eq("starve_win", {30'd0, cpu_gnt, host_gnt}, 2'b01);
        check_eq("starve_raddr", 32'(mem_raddr), 3);
        host_q.push_back(8'h43);
      end
    end
    step(1, 4'd1, 0, 0, 4'd0, 8'h00);
    check_eq("cpu_regains", {30'd0, cpu_gnt, host_gnt}, 2'b10);
    cpu_q.push_back(8'h11);

    // Same-address write and fetch: write-first memory returns the new data.
    step(1, 4'd2, 1, 1, 4'd2, 8'hAA);
    check_eq("parallel_grants", {29'd0, cpu_gnt, host_gnt, mem_wen}, 3'b111);
    cpu_q.push_back(8'hAA);

    // Idle CPU: host read wins immediately.
    step(0, 4'd0, 1, 0, 4'd5, 8'h00);
    check_eq("idle_host_gnt", {30'd0, cpu_gnt, host_gnt}, 2'b01);
    host_q.push_back(8'hFB);
    @(posedge clk); #1;
    check_eq("idle_wait_cnt", 32'(dut.wait_cnt), 0);
    step(0, 4'd0, 0, 0, 4'd0, 8'h00);
    check_eq("idle_no_grant", {30'd0, mem_ren, mem_wen}, 0);

    // Reset in the cycle after a CPU grant drops the in-flight rvalid.
    step(1, 4'd0, 0, 0, 4'd0, 8'h00);
    check_eq("pre_reset_gnt", {31'd0, cpu_gnt}, 1);
    @(posedge clk); #1;
    rst_i = 1'b0;
    #1;
    check_eq("reset_drops_rvalid", {30'd0, cpu_rvalid, ready}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_i = 1'b1;
    @(posedge clk);
    for (int k = 2; k <= 16; k++) begin
      @(negedge clk); #1;
      check_eq("reinit_holdoff", {27'd0, cpu_gnt, host_gnt, mem_ren, mem_wen, ready}, 0);
      @(posedge clk);
    end
    @(negedge clk); #1;
    check_eq("reinit_gnt", {30'd0, cpu_gnt, ready}, 2'b11);
    cpu_q.push_back(8'h45);

    step(0, 4'd0, 0, 0, 4'd0, 8'h00);
    repeat (3) @(negedge clk);
    check_eq("cpu_queue_drained", 32'(cpu_q.size()), 0);
    check_eq("host_queue_drained", 32'(host_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
